decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports, in this order:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- inst_de  in  32  instruction in decode.
- muxData  in  32  write-back data.
- RuWr_wb  in  1  write-back register write enable.
- rd_wb  in  5  write-back destination register.
- DMRd_ex  in  1  instruction in EX is a load.
- rd_ex  in  5  EX destination register.
- ru1, ru2  out  32  register-file read data for rs1 and rs2.
- ImmExt  out  32  sign-extended immediate.
- AluASrc  out  1  ALU A source: 0=ru1, 1=PC.
- AluBSrc  out  1  ALU B source: 0=ru2, 1=ImmExt.
- RuWr  out  1  register write enable.
- DMWr  out  1  data-memory write enable.
- RUDataWrSrc  out  2  write-back source: 00=ALU, 01=memory, 10=PC+4.
- AluOp  out  4  ALU operation.
- BrOp  out  5  branch operation.
- DMCtrl  out  3  memory access width/sign.
- rs1_de, rs2_de, rd_de  out  5  inst[19:15], inst[24:20], inst[11:7].
- clr  out  1  flush the DE/EX control register.
- en_pc_fe  out  1  PC register enable.
- en_pc_inc_de  out  1  FE/DE register enable.

Function
REQ-002 SHALL contain a 32x32 register file; x0 reads 0 and ignores writes.
REQ-003 Write: on rising clk edge, if RuWr_wb=1 and rd_wb!=0, SHALL write muxData to x[rd_wb].
REQ-004 Reads SHALL be combinational, with write-through: if RuWr_wb=1, rd_wb!=0 and rd_wb equals the read index, the output is muxData.
REQ-005 Immediates SHALL be sign-extended, per instruction format:
- I-type (OP-IMM, LOAD, JALR): inst[31:20].
- S-type: {inst[31:25], inst[11:7]}.
- B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U-type: {inst[31:12], 12'b0}.
- J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Other opcodes: 0.
REQ-006 Control signals SHALL be set by opcode:
- R 0110011: AluOp={f7[5],f3}, A=0, B=0, RuWr=1, src=00.
- I 0010011: AluOp={f3==101 ? f7[5] : 0, f3}, A=0, B=1, RuWr=1, src=00.
- LOAD 0000011: AluOp=0000, B=1, RuWr=1, src=01, DMCtrl=f3.
- STORE 0100011: AluOp=0000, B=1, DMWr=1, RuWr=0, DMCtrl=f3.
- BRANCH 1100011: A=1, B=1, AluOp=0000, BrOp={2'b01,f3}, RuWr=0.
- JAL 1101111: A=1, B=1, AluOp=0000, BrOp=10000, RuWr=1, src=10.
- JALR 1100111: A=0, B=1, AluOp=0000, BrOp=10000, RuWr=1, src=10.
- LUI 0110111: AluOp=1111 (pass B), B=1, RuWr=1, src=00.
- AUIPC 0010111: A=1, B=1, AluOp=0000, RuWr=1, src=00.
REQ-007 Any field not listed in REQ-006 SHALL be 0. BrOp=00000 means no branch. DMCtrl SHALL be f3 for every opcode.
REQ-008 An unknown opcode SHALL drive all control outputs to 0, so RuWr=0 and DMWr=0.
REQ-009 Load-use hazard: when DMRd_ex=1, rd_ex!=0 and (rd_ex==rs1_de or rd_ex==rs2_de), SHALL drive clr=1, en_pc_fe=0, en_pc_inc_de=0.
REQ-010 The hazard check SHALL compare both rs fields regardless of instruction format.
REQ-011 With no hazard, SHALL drive clr=0, en_pc_fe=1, en_pc_inc_de=1.
REQ-012 All outputs except register-file contents SHALL be combinational, with zero-cycle latency.

Reset
REQ-013 rst=1 SHALL asynchronously clear all 32 registers to 0 and block writes while asserted; combinational outputs keep following their inputs.
REQ-014 Deassertion mid-operation SHALL need no sequencing; the first write happens on the first rising edge with rst=0.

Verification
REQ-015 Reset, then inst=addi x1,x0,5 (0x00500093) -> ImmExt=5, AluBSrc=1, RuWr=1, AluOp=0000, rs1_de=0, rd_de=1, ru1=0.
REQ-016 RuWr_wb=1, rd_wb=3, muxData=0xDEADBEEF, then inst with rs1=3 -> ru1=0xDEADBEEF combinationally in the same cycle and after the edge; the same test with rd_wb=0 -> x0 stays 0.
REQ-017 inst=beq x1,x2,-8 (0xFE208CE3) -> ImmExt=0xFFFFFFF8, BrOp=01000, AluASrc=1, RuWr=0.
REQ-018 DMRd_ex=1, rd_ex=5, inst=add x6,x5,x7 -> clr=1, en_pc_fe=0, en_pc_inc_de=0; rd_ex=0 or DMRd_ex=0 -> 0/1/1.
REQ-019 inst=jal x1,+16 (0x010000EF) -> ImmExt=16, BrOp=10000, RUDataWrSrc=10; inst=0xFFFFFFFF -> all control outputs 0.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: 32x32 register file with write-through reads, immediate
// generation, control decode and load-use hazard detection.
module decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_de,
   input  logic [31:0] muxData,
   input  logic        RuWr_wb,
   input  logic [4:0]  rd_wb,
   input  logic        DMRd_ex,
   input  logic [4:0]  rd_ex,
   output logic [31:0] ru1,
   output logic [31:0] ru2,
   output logic [31:0] ImmExt,
   output logic        AluASrc,
   output logic        AluBSrc,
   output logic        RuWr,
   output logic        DMWr,
   output logic [1:0]  RUDataWrSrc,
   output logic [3:0]  AluOp,
   output logic [4:0]  BrOp,
   output logic [2:0]  DMCtrl,
   output logic [4:0]  rs1_de,
   output logic [4:0]  rs2_de,
   output logic [4:0]  rd_de,
   output logic        clr,
   output logic        en_pc_fe,
   output logic        en_pc_inc_de
);

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   logic [31:0] regFile [32];
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        f7b5;
   logic        wbActive;

   assign opcode = inst_de[6:0];
   assign funct3 = inst_de[14:12];
   assign f7b5   = inst_de[30];
   assign rs1_de = inst_de[19:15];
   assign rs2_de = inst_de[24:20];
   assign rd_de  = inst_de[11:7];

   assign wbActive = RuWr_wb && (rd_wb != 5'd0);

   // x0 is never written, so its entry stays at the reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 32; k++) regFile[k] <= 32'd0;
      end else if (wbActive) begin
         regFile[rd_wb] <= muxData;
      end
   end

   assign ru1 = (wbActive && rd_wb == rs1_de) ? muxData : regFile[rs1_de];
   assign ru2 = (wbActive && rd_wb == rs2_de) ? muxData : regFile[rs2_de];

   always_comb begin
      ImmExt = 32'd0;
      unique case (opcode)
         OpImm, OpLoad, OpJalr: ImmExt = {{20{inst_de[31]}}, inst_de[31:20]};
         OpStore:  ImmExt = {{20{inst_de[31]}}, inst_de[31:25], inst_de[11:7]};
         OpBranch: ImmExt = {{19{inst_de[31]}}, inst_de[31], inst_de[7],
                             inst_de[30:25], inst_de[11:8], 1'b0};
         OpLui, OpAuipc: ImmExt = {inst_de[31:12], 12'd0};
         OpJal:    ImmExt = {{11{inst_de[31]}}, inst_de[31], inst_de[19:12],
                             inst_de[20], inst_de[30:21], 1'b0};
         default:  ImmExt = 32'd0;
      endcase
   end

   // Unknown opcodes leave every control field at zero, including DMCtrl.
   always_comb begin
      AluASrc     = 1'b0;
      AluBSrc     = 1'b0;
      RuWr        = 1'b0;
      DMWr        = 1'b0;
      RUDataWrSrc = 2'b00;
      AluOp       = 4'b0000;
      BrOp        = 5'b00000;
      DMCtrl      = 3'b000;
      unique case (opcode)
         OpR: begin
            AluOp  = {f7b5, funct3};
            RuWr   = 1'b1;
            DMCtrl = funct3;
         end
         OpImm: begin
            AluOp   = {(funct3 == 3'b101) ? f7b5 : 1'b0, funct3};
            AluBSrc = 1'b1;
            RuWr    = 1'b1;
            DMCtrl  = funct3;
         end
         OpLoad: begin
            AluBSrc     = 1'b1;
            RuWr        = 1'b1;
            RUDataWrSrc = 2'b01;
            DMCtrl      = funct3;
         end
         OpStore: begin
            AluBSrc = 1'b1;
            DMWr    = 1'b1;
            DMCtrl  = funct3;
         end
         OpBranch: begin
            AluASrc = 1'b1;
            AluBSrc = 1'b1;
            BrOp    = {2'b01, funct3};
            DMCtrl  = funct3;
         end
         OpJal: begin
            AluASrc     = 1'b1;
            AluBSrc     = 1'b1;
            BrOp        = 5'b10000;
            RuWr        = 1'b1;
            RUDataWrSrc = 2'b10;
            DMCtrl      = funct3;
         end
         OpJalr: begin
            AluBSrc     = 1'b1;
            BrOp        = 5'b10000;
            RuWr        = 1'b1;
            RUDataWrSrc = 2'b10;
            DMCtrl      = funct3;
         end
         OpLui: begin
            AluOp   = 4'b1111;
            AluBSrc = 1'b1;
            RuWr    = 1'b1;
            DMCtrl  = funct3;
         end
         OpAuipc: begin
            AluASrc = 1'b1;
            AluBSrc = 1'b1;
            RuWr    = 1'b1;
            DMCtrl  = funct3;
         end
         default: ;
      endcase
   end

   // Both rs fields are compared even for formats that do not use them.
   logic loadUse;
   assign loadUse      = DMRd_ex && (rd_ex != 5'd0) &&
                         ((rd_ex == rs1_de) || (rd_ex == rs2_de));
   assign clr          = loadUse;
   assign en_pc_fe     = !loadUse;
   assign en_pc_inc_de = !loadUse;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a table-level reference model.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_de, muxData;
   logic        RuWr_wb, DMRd_ex;
   logic [4:0]  rd_wb, rd_ex;
   logic [31:0] ru1, ru2, ImmExt;
   logic        AluASrc, AluBSrc, RuWr, DMWr;
   logic [1:0]  RUDataWrSrc;
   logic [3:0]  AluOp;
   logic [4:0]  BrOp;
   logic [2:0]  DMCtrl;
   logic [4:0]  rs1_de, rs2_de, rd_de;
   logic        clr, en_pc_fe, en_pc_inc_de;

   int nChecks = 0;
   int nPass   = 0;
   logic [31:0] refRegs [32];

   decode_stage dut (
      .clk(clk), .rst(rst), .inst_de(inst_de), .muxData(muxData),
      .RuWr_wb(RuWr_wb), .rd_wb(rd_wb), .DMRd_ex(DMRd_ex), .rd_ex(rd_ex),
      .ru1(ru1), .ru2(ru2), .ImmExt(ImmExt), .AluASrc(AluASrc),
      .AluBSrc(AluBSrc), .RuWr(RuWr), .DMWr(DMWr), .RUDataWrSrc(RUDataWrSrc),
      .AluOp(AluOp), .BrOp(BrOp), .DMCtrl(DMCtrl), .rs1_de(rs1_de),
      .rs2_de(rs2_de), .rd_de(rd_de), .clr(clr), .en_pc_fe(en_pc_fe),
      .en_pc_inc_de(en_pc_inc_de)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // {A, B, RuWr, DMWr, src[1:0], AluOp[3:0], BrOp[4:0], DMCtrl[2:0]}
   function automatic logic [17:0] ctrlWord();
      return {AluASrc, AluBSrc, RuWr, DMWr, RUDataWrSrc, AluOp, BrOp, DMCtrl};
   endfunction

   function automatic logic [17:0] refCtrl(input logic [31:0] i);
      logic a, b, w, m;
      logic [1:0] s;
      logic [3:0] op;
      logic [4:0] br;
      logic [2:0] f3;
      f3 = i[14:12];
      {a, b, w, m, s, op, br} = '0;
      case (i[6:0])
         7'h33: begin op = {i[30], f3}; w = 1; end
         7'h13: begin op = {(f3 == 3'd5) && i[30], f3}; b = 1; w = 1; end
         7'h03: begin b = 1; w = 1; s = 2'd1; end
         7'h23: begin b = 1; m = 1; end
         7'h63: begin a = 1; b = 1; br = 5'd8 + f3; end
         7'h6F: begin a = 1; b = 1; br = 5'd16; w = 1; s = 2'd2; end
         7'h67: begin b = 1; br = 5'd16; w = 1; s = 2'd2; end
         7'h37: begin op = 4'd15; b = 1; w = 1; end
         7'h17: begin a = 1; b = 1; w = 1; end
         default: return 18'd0;
      endcase
      return {a, b, w, m, s, op, br, f3};
   endfunction

   function automatic logic [31:0] refImm(input logic [31:0] i);
      int v;
      case (i[6:0])
         7'h13, 7'h03, 7'h67: v = $signed(i) >>> 20;
         7'h23: v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
         7'h63: v = (($signed(i) >>> 31) * 4096) + int'(i[7]) * 2048
                    + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
         7'h37, 7'h17: v = int'(i & 32'hFFFFF000);
         7'h6F: v = (($signed(i) >>> 31) * 1048576) + int'(i[19:12]) * 4096
                    + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] refRead(input logic [4:0] idx);
      if (idx == 0) return 32'd0;
      if (RuWr_wb && rd_wb == idx) return muxData;
      return refRegs[idx];
   endfunction

   task automatic checkAll(input string tag);
      logic haz;
      check({tag, ".ru1"}, ru1, refRead(inst_de[19:15]));
      check({tag, ".ru2"}, ru2, refRead(inst_de[24:20]));
      check({tag, ".imm"}, ImmExt, refImm(inst_de));
      check({tag, ".ctrl"}, 32'(ctrlWord()), 32'(refCtrl(inst_de)));
      check({tag, ".fields"}, {17'd0, rs1_de, rs2_de, rd_de},
            {17'd0, inst_de[19:15], inst_de[24:20], inst_de[11:7]});
      haz = DMRd_ex && rd_ex != 0 && (rd_ex == inst_de[19:15] || rd_ex == inst_de[24:20]);
      check({tag, ".haz"}, {29'd0, clr, en_pc_fe, en_pc_inc_de}, {29'd0, haz, !haz, !haz});
   endtask

   task automatic clockModel();
      @(posedge clk);
      if (!rst && RuWr_wb && rd_wb != 0) refRegs[rd_wb] = muxData;
      @(negedge clk);
   endtask

   initial begin
      logic [6:0] ops [9];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      for (int k = 0; k < 32; k++) refRegs[k] = 32'd0;
      rst = 1; inst_de = 0; muxData = 0; RuWr_wb = 0; rd_wb = 0; DMRd_ex = 0; rd_ex = 0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 32; k += 7) begin
         inst_de = {7'd0, 5'(k + 3), 5'(k), 3'd0, 5'd0, 7'h33};
         #1 check("rst.ru1", ru1, 0);
         check("rst.ru2", ru2, 0);
      end
      rst = 0;
      @(negedge clk);

      inst_de = 32'h00500093; #1;
      check("addi.imm", ImmExt, 5);
      check("addi.ctrl", {AluBSrc, RuWr, AluOp, 27'd0}, {1'b1, 1'b1, 4'd0, 27'd0});
      check("addi.rs1rd", {rs1_de, rd_de}, {5'd0, 5'd1});
      check("addi.ru1", ru1, 0);

      RuWr_wb = 1; rd_wb = 3; muxData = 32'hDEADBEEF;
      inst_de = {12'd0, 5'd3, 3'd0, 5'd4, 7'h13}; #1;
      check("wt.same", ru1, 32'hDEADBEEF);
      clockModel();
      RuWr_wb = 0; muxData = 0; #1;
      check("wt.after", ru1, 32'hDEADBEEF);
      RuWr_wb = 1; rd_wb = 0; muxData = 32'h12345678;
      inst_de = {12'd0, 5'd0, 3'd0, 5'd4, 7'h13}; #1;
      check("x0.same", ru1, 0);
      clockModel();
      RuWr_wb = 0; #1;
      check("x0.after", ru1, 0);

      inst_de = 32'hFE208CE3; #1;
      check("beq.imm", ImmExt, 32'hFFFFFFF8);
      check("beq.ctrl", {BrOp, AluASrc, RuWr}, {5'b01000, 1'b1, 1'b0});

      DMRd_ex = 1; rd_ex = 5; inst_de = 32'h00728333; #1;
      check("lu.haz", {clr, en_pc_fe, en_pc_inc_de}, 3'b100);
      rd_ex = 0; #1;
      check("lu.rd0", {clr, en_pc_fe, en_pc_inc_de}, 3'b011);
      rd_ex = 7; #1;
      check("lu.rs2", {clr, en_pc_fe, en_pc_inc_de}, 3'b100);
      DMRd_ex = 0; #1;
      check("lu.noload", {clr, en_pc_fe, en_pc_inc_de}, 3'b011);

      inst_de = 32'h010000EF; #1;
      check("jal.imm", ImmExt, 16);
      check("jal.ctrl", {BrOp, RUDataWrSrc}, {5'b10000, 2'b10});
      inst_de = 32'hFFFFFFFF; #1;
      check("bad.ctrl", 32'(ctrlWord()), 0);
      check("bad.imm", ImmExt, 0);
      @(negedge clk);

      for (int n = 0; n < 400; n++) begin
         inst_de = $urandom;
         if ($urandom_range(0, 9) != 0) inst_de[6:0] = ops[$urandom_range(0, 8)];
         RuWr_wb = $urandom_range(0, 2) != 0;
         rd_wb   = ($urandom_range(0, 3) == 0) ? inst_de[19:15] : 5'($urandom);
         muxData = $urandom;
         DMRd_ex = $urandom;
         rd_ex   = ($urandom_range(0, 2) == 0) ? inst_de[24:20] : 5'($urandom);
         #1 checkAll("rnd");
         if (n == 250) begin
            #1 rst = 1; RuWr_wb = 0;
            for (int k = 0; k < 32; k++) refRegs[k] = 32'd0;
            #1 check("midrst.ru1", ru1, 0);
            check("midrst.ru2", ru2, 0);
            RuWr_wb = 1; rd_wb = 9; muxData = 32'hA5A5A5A5;
            clockModel();
            rst = 0; RuWr_wb = 0;
            inst_de = {12'd0, 5'd9, 3'd0, 5'd1, 7'h13}; #1;
            check("midrst.blocked", ru1, 0);
         end
         clockModel();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
